// File: rtl/nn_int_pkg.sv
// Shared integer-NN types and the requantization helper.
// Widths, activation entry type, ReLU/round/shift/saturate function.
package nn_int_pkg;

  localparam int ACC_W   = 16;
  localparam int ACT_W   = 8;
  localparam int BIAS_W  = 16;
  localparam int ACT_MAX = 255;

  // Bias-added accumulator: 16-bit unsigned plus 16-bit signed.
  localparam int SUM_W   = ACC_W + 2;
  localparam int RND_W   = SUM_W + 1;

  typedef struct packed {
    logic             last;
    logic [ACT_W-1:0] act;
  } act_entry_t;

  function automatic logic [ACT_W-1:0] requant(
    input logic signed [SUM_W-1:0] acc,
    input int                      shift
  );
    logic [RND_W-1:0] mag;
    logic [RND_W-1:0] rnd;
    logic [RND_W-1:0] r;
    logic [ACT_W-1:0] res;
    mag = {2'b00, acc[SUM_W-2:0]};
    rnd = '0;
    if (shift > 0)
      rnd = RND_W'(1) << (shift - 1);
    r = (mag + rnd) >> shift;
    if (acc[SUM_W-1])
      res = '0;
    else if (r > RND_W'(ACT_MAX))
      res = ACT_W'(ACT_MAX);
    else
      res = r[ACT_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with exact occupancy count.
// Ports: push/din in, pop in, dout head (0 when empty), count/full/empty.
module sync_fifo
  import nn_int_pkg::*;
#(
  parameter int W     = $bits(act_entry_t),
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees a slot.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/neuron_requantize.sv
// Bias add, ReLU, round/shift, saturate; buffers 8-bit activations.
// Ports: in_valid/in_data from MAC, bias table write, out stream, overflow.
module neuron_requantize
  import nn_int_pkg::*;
#(
  parameter int NEURONS = 4,
  parameter int SHIFT   = 4,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [ACC_W-1:0]           in_data,
  input  logic                       layer_start,
  input  logic                       bias_we,
  input  logic [$clog2(NEURONS)-1:0] bias_addr,
  input  logic [BIAS_W-1:0]          bias_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACT_W-1:0]           out_data,
  output logic                       out_last,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int IW = $clog2(NEURONS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NEURONS - 1);

  logic [IW-1:0]             idx;
  logic [IW-1:0]             sample_idx;
  logic signed [BIAS_W-1:0]  bias [NEURONS];
  logic signed [BIAS_W-1:0]  bias_sel;
  logic signed [SUM_W-1:0]   acc_next;

  logic                      s1_valid;
  logic                      s1_last;
  logic signed [SUM_W-1:0]   s1_acc;
  logic                      s2_valid;
  act_entry_t                s2_entry;

  act_entry_t                head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;

  // layer_start rebases the sample in the same cycle.
  assign sample_idx = layer_start ? '0 : idx;
  // Array read sees the pre-write value on a same-cycle write.
  assign bias_sel   = bias[sample_idx];
  assign acc_next   = $signed({2'b00, in_data})
                    + {{(SUM_W-BIAS_W){bias_sel[BIAS_W-1]}},
                       bias_sel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (layer_start && in_valid) begin
      idx <= (NEURONS > 1) ? IW'(1) : '0;
    end else if (layer_start) begin
      idx <= '0;
    end else if (in_valid) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NEURONS; i++)
        bias[i] <= '0;
    end else if (bias_we) begin
      bias[bias_addr] <= bias_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_acc   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_acc  <= acc_next;
        s1_last <= (sample_idx == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_entry <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_entry.last <= s1_last;
        s2_entry.act  <= requant(s1_acc, SHIFT);
      end
    end
  end

  sync_fifo #(
    .W     ($bits(act_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s2_valid),
    .din   (s2_entry),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign out_data  = head.act;
  assign out_last  = head.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (s2_valid && fifo_full && !pop)
      overflow <= 1'b1;
  end

endmodule

// File: tb/tb_neuron_requantize.sv
// Directed bench for neuron_requantize (NEURONS=4, SHIFT=4, DEPTH=8).
// Hand-computed expectations checked with immediate assertions.
module tb_neuron_requantize;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        layer_start = 1'b0;
  logic        bias_we = 1'b0;
  logic [1:0]  bias_addr = '0;
  logic [15:0] bias_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic        overflow;
  logic [3:0]  fifo_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  neuron_requantize #(
    .NEURONS (4),
    .SHIFT   (4),
    .DEPTH   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .layer_start (layer_start),
    .bias_we     (bias_we),
    .bias_addr   (bias_addr),
    .bias_data   (bias_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic setb(input logic [1:0] a,
                      input logic [15:0] v);
    bias_we   = 1'b1;
    bias_addr = a;
    bias_data = v;
    step();
    bias_we = 1'b0;
  endtask

  task automatic settle();
    step();
    step();
    step();
  endtask

  task automatic popchk(input string tag,
                        input logic [7:0] d,
                        input logic l);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_last"}, out_last, l);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    step();
    rst_n = 1'b1;
    step();

    // requant basics and latency
    in_valid = 1'b1;
    in_data  = 16'd256;
    step();
    in_data  = 16'd24;
    step();
    chk("lat_early", out_valid, 0);
    in_data  = 16'd23;
    step();
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 16);
    in_data  = 16'd8192;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("basic_count", fifo_count, 4);
    popchk("b0", 8'd16, 1'b0);
    popchk("b1", 8'd2, 1'b0);
    popchk("b2", 8'd1, 1'b0);
    popchk("b3", 8'd255, 1'b1);
    chk("basic_empty", out_valid, 0);

    // bias and ReLU
    setb(2'd1, 16'hFED4);
    setb(2'd2, 16'd40);
    send(16'd256);
    send(16'd256);
    send(16'd256);
    send(16'd0);
    settle();
    chk("relu_count", fifo_count, 4);
    popchk("r0", 8'd16, 1'b0);
    popchk("r1", 8'd0, 1'b0);
    popchk("r2", 8'd19, 1'b0);
    popchk("r3", 8'd0, 1'b1);
    setb(2'd1, 16'hFF00);
    send(16'd0);
    send(16'd256);
    settle();
    popchk("z0", 8'd0, 1'b0);
    popchk("z1", 8'd0, 1'b0);

    // bias write hazard
    layer_start = 1'b1;
    step();
    layer_start = 1'b0;
    bias_we   = 1'b1;
    bias_addr = 2'd0;
    bias_data = 16'd160;
    in_valid  = 1'b1;
    in_data   = 16'd0;
    step();
    bias_we  = 1'b0;
    in_valid = 1'b0;
    send(16'd0);
    send(16'd0);
    send(16'd0);
    send(16'd0);
    settle();
    chk("haz_count", fifo_count, 5);
    popchk("h0", 8'd0, 1'b0);
    popchk("h1", 8'd0, 1'b0);
    popchk("h2", 8'd3, 1'b0);
    popchk("h3", 8'd0, 1'b1);
    popchk("h4", 8'd10, 1'b0);

    // layer_start with a sample
    send(16'd0);
    send(16'd0);
    layer_start = 1'b1;
    send(16'd0);
    layer_start = 1'b0;
    send(16'd0);
    send(16'd0);
    send(16'd0);
    settle();
    chk("ls_count", fifo_count, 6);
    popchk("l0", 8'd0, 1'b0);
    popchk("l1", 8'd3, 1'b0);
    popchk("l2", 8'd10, 1'b0);
    popchk("l3", 8'd0, 1'b0);
    popchk("l4", 8'd3, 1'b0);
    popchk("l5", 8'd0, 1'b1);

    // overflow
    setb(2'd0, 16'd0);
    setb(2'd1, 16'd0);
    setb(2'd2, 16'd0);
    chk("ovf_pre", overflow, 0);
    for (int k = 1; k <= 9; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(16 * k);
      step();
    end
    in_valid = 1'b0;
    settle();
    chk("ovf_count", fifo_count, 8);
    chk("ovf_flag", overflow, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("ovf_drain", out_data, k);
      step();
    end
    out_ready = 1'b0;
    chk("ovf_empty", out_valid, 0);
    chk("ovf_cnt0", fifo_count, 0);
    chk("ovf_sticky", overflow, 1);

    // full push+pop same cycle
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rst2_ovf", overflow, 0);
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(16 * k);
      step();
    end
    in_valid = 1'b0;
    settle();
    chk("full_count", fifo_count, 8);
    send(16'd160);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pp_count", fifo_count, 8);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", out_data, 2);
    out_ready = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      chk("pp_drain", out_data, k);
      step();
    end
    chk("pp_tail", out_data, 10);
    step();
    out_ready = 1'b0;
    chk("pp_cnt0", fifo_count, 0);

    // async reset mid-stream
    setb(2'd0, 16'd160);
    setb(2'd1, 16'd160);
    send(16'd0);
    send(16'd0);
    step();
    chk("ar_pre", out_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_data", out_data, 0);
    chk("ar_count", fifo_count, 0);
    chk("ar_last", out_last, 0);
    step();
    rst_n = 1'b1;
    send(16'd0);
    settle();
    chk("ar_cnt1", fifo_count, 1);
    popchk("ar_s0", 8'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
